// File: rtl/daq_pkg.sv
// daq_pkg: shared widths and FSM state encoding for the ADC readout sequencer.
//   DATA_W  - ADC sample width
//   CH_W    - channel index width
//   ST_*    - readout state encoding
package daq_pkg;
    localparam int DATA_W = 16;
    localparam int CH_W   = 3;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CONV    = 3'd1;
    localparam state_t ST_WAIT_HI = 3'd2;
    localparam state_t ST_WAIT_LO = 3'd3;
    localparam state_t ST_RD_LOW  = 3'd4;
    localparam state_t ST_RD_HIGH = 3'd5;
    localparam state_t ST_PUSH    = 3'd6;
endpackage

// File: rtl/daq_sync2.sv
// daq_sync2: two-flop synchronizer for a single asynchronous input.
//   clk_i   - destination clock
//   reset_i - asynchronous active-high reset, clears both flops
//   d       - asynchronous input
//   q       - synchronized output
module daq_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/adc_readout_seq.sv
// adc_readout_seq: periodic frame sequencer for a parallel-bus ADC with valid/ready sample output.
//   clk_i, reset_i       - clock, asynchronous active-high reset
//   en_i                 - enables frame ticks (a running frame always completes)
//   clear_i              - clears sticky overrun_o/timeout_o
//   busy_i, db_i         - ADC busy (asynchronous) and data bus
//   conv_n_o, cs_n_o, rd_n_o - ADC conversion start, chip select, read strobe (active-low)
//   sample_o, chan_o, valid_o, ready_i - sample stream handshake
//   frame_done_o         - one-cycle pulse after the last channel is accepted
//   overrun_o, timeout_o - sticky error flags
module adc_readout_seq
    import daq_pkg::*;
#(
    parameter int NUM_CH          = 8,
    parameter int PERIOD_CYCLES   = 1000,
    parameter int CONV_LOW_CYCLES = 10,
    parameter int RD_LOW_CYCLES   = 4,
    parameter int RD_HIGH_CYCLES  = 2,
    parameter int BUSY_TIMEOUT    = 500
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              busy_i,
    input  logic [DATA_W-1:0] db_i,
    output logic              conv_n_o,
    output logic              cs_n_o,
    output logic              rd_n_o,
    output logic [DATA_W-1:0] sample_o,
    output logic [CH_W-1:0]   chan_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic              timeout_o
);
    logic            busy_s;
    logic            tick;
    logic            last;
    logic            to;
    logic [31:0]     per_cnt;
    logic [31:0]     cnt;
    logic [CH_W-1:0] ch;
    state_t          state;
    state_t          nxt;

    daq_sync2 u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d      (busy_i),
        .q      (busy_s)
    );

    // Tick is registered so the first conversion starts PERIOD_CYCLES+1 cycles after enable.
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            per_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            per_cnt <= (!en_i || per_cnt == PERIOD_CYCLES - 1) ? '0 : per_cnt + 1;
            tick    <= en_i && per_cnt == PERIOD_CYCLES - 1;
        end

    assign last = ch == CH_W'(NUM_CH - 1);

    always_comb begin
        nxt = state;
        to  = 1'b0;
        case (state)
            ST_IDLE:    nxt = tick ? ST_CONV : ST_IDLE;
            ST_CONV:    if (cnt == CONV_LOW_CYCLES - 1) nxt = ST_WAIT_HI;
            ST_WAIT_HI:
                if (busy_s) nxt = ST_WAIT_LO;
                else if (cnt == BUSY_TIMEOUT - 1) begin
                    nxt = ST_IDLE;
                    to  = 1'b1;
                end
            ST_WAIT_LO:
                if (!busy_s) nxt = ST_RD_LOW;
                else if (cnt == BUSY_TIMEOUT - 1) begin
                    nxt = ST_IDLE;
                    to  = 1'b1;
                end
            ST_RD_LOW:  if (cnt == RD_LOW_CYCLES - 1) nxt = ST_PUSH;
            ST_PUSH:    if (ready_i) nxt = last ? ST_IDLE : ST_RD_HIGH;
            ST_RD_HIGH: if (cnt == RD_HIGH_CYCLES - 1) nxt = ST_RD_LOW;
            default:    nxt = ST_IDLE;
        endcase
    end

    // The shared phase counter restarts on every state change; it is parked in untimed states.
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ch           <= '0;
            sample_o     <= '0;
            chan_o       <= '0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || state == ST_IDLE || state == ST_PUSH) ? '0 : cnt + 1;
            if (state == ST_IDLE && tick) ch <= '0;
            else if (state == ST_PUSH && ready_i && !last) ch <= ch + 1'b1;
            if (state == ST_RD_LOW && nxt == ST_PUSH) begin
                sample_o <= db_i;
                chan_o   <= ch;
            end
            frame_done_o <= state == ST_PUSH && ready_i && last;
            overrun_o    <= (tick && state != ST_IDLE) || (overrun_o && !clear_i);
            timeout_o    <= to || (timeout_o && !clear_i);
        end

    assign conv_n_o = state != ST_CONV;
    assign rd_n_o   = state != ST_RD_LOW;
    assign cs_n_o   = !(state == ST_RD_LOW || state == ST_PUSH || state == ST_RD_HIGH);
    assign valid_o  = state == ST_PUSH;
endmodule

// File: tb/tb_adc_readout_seq.sv
// tb_adc_readout_seq: scoreboard bench for adc_readout_seq with a behavioural ADC model.
module tb_adc_readout_seq;
    localparam int P = 50;
    logic        clk = 0, reset = 1, en = 0, clear = 0, busy = 0, ready = 1;
    logic [15:0] db = 0;
    logic        conv_n, cs_n, rd_n, valid, frame_done, overrun, timeout;
    logic [15:0] sample;
    logic [2:0]  chan;
    logic [18:0] exp_q[$];
    logic [18:0] e;
    int checks = 0, errors = 0;
    int adc_base = 0, idx = 0, lc = 0, sc = -1, rd_pulses = 0, fd_count = 0;
    bit dead = 0;

    adc_readout_seq #(.PERIOD_CYCLES(P)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .busy_i(busy), .db_i(db),
        .conv_n_o(conv_n), .cs_n_o(cs_n), .rd_n_o(rd_n), .sample_o(sample), .chan_o(chan),
        .valid_o(valid), .ready_i(ready), .frame_done_o(frame_done), .overrun_o(overrun),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ADC model: busy pulses 5..24 cycles after conversion start ends; data changes every
    // low-strobe cycle so only a capture on the last RD_LOW cycle yields base+idx*16+3.
    always @(negedge clk) begin
        if (reset) begin
            sc = -1; idx = 0; lc = 0; busy = 0;
        end else begin
            if (!conv_n) begin
                sc = 0; idx = 0;
            end else if (sc >= 0 && sc < 1000) sc++;
            busy = !dead && sc >= 5 && sc < 25;
            if (!rd_n) begin
                db = 16'(adc_base + idx * 16 + lc);
                lc++;
            end else if (lc != 0) begin
                idx++; rd_pulses++; lc = 0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (frame_done) fd_count++;
            if (valid && ready) begin
                if (exp_q.size() == 0) check("unexpected sample", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("chan", int'(chan), int'(e[18:16]));
                    check("data", int'(sample), int'(e[15:0]));
                end
            end
        end
    end

    task automatic push_frame(input int base);
        adc_base = base; rd_pulses = 0; fd_count = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'(base + i * 16 + 3)});
    endtask

    task automatic wait_conv(input string name);
        int k = 0;
        while (conv_n && k < 300) begin @(negedge clk); k++; end
        check({name, " conv start"}, int'(conv_n), 0);
    endtask

    task automatic finish_frame(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        check({name, " leftover"}, exp_q.size(), 0);
        check({name, " rd pulses"}, rd_pulses, 8);
        check({name, " frame_done"}, fd_count, 1);
        check({name, " cs_n idle"}, int'(cs_n), 1);
        exp_q.delete();
    endtask

    initial begin
        int n, w;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst conv_n", int'(conv_n), 1);
        check("rst cs_n", int'(cs_n), 1);
        check("rst rd_n", int'(rd_n), 1);
        check("rst valid", int'(valid), 0);
        check("rst sample", int'(sample), 0);
        check("rst flags", int'({overrun, timeout, frame_done}), 0);

        push_frame(16'h1000);
        en = 1; reset = 0;
        n = 0;
        while (conv_n && n < 300) begin @(negedge clk); n++; end
        check("first conv latency", n, P + 1);
        en = 0;
        w = 0;
        while (!conv_n && w < 50) begin @(negedge clk); w++; end
        check("conv width", w, 10);
        finish_frame("nominal");
        check("no overrun", int'(overrun), 0);

        push_frame(16'h2000);
        en = 1; wait_conv("bp"); en = 0;
        n = 0;
        while (!(idx == 3 && !rd_n) && n < 400) begin @(negedge clk); n++; end
        ready = 0; seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid && !rd_n) seen = 1;
        end
        check("bp valid held", int'(valid), 1);
        check("bp chan held", int'(chan), 3);
        check("bp sample held", int'(sample), 16'h2033);
        check("bp rd_n idle", int'(rd_n) + int'(seen), 1);
        ready = 1;
        finish_frame("bp");

        dead = 1; rd_pulses = 0;
        en = 1; wait_conv("to"); en = 0;
        n = 0;
        while (!conv_n && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (!timeout && n < 700) begin @(negedge clk); n++; end
        check("timeout latency", n, 500);
        check("timeout no reads", rd_pulses, 0);
        check("timeout cs_n", int'(cs_n), 1);
        clear = 1; @(negedge clk); clear = 0;
        check("timeout cleared", int'(timeout), 0);
        dead = 0;

        ready = 0;
        push_frame(16'h3000);
        en = 1; wait_conv("ovr");
        repeat (60) @(negedge clk);
        check("overrun set", int'(overrun), 1);
        en = 0; ready = 1;
        finish_frame("ovr");

        push_frame(16'h4000);
        en = 1; wait_conv("rst"); en = 0;
        n = 0;
        while (!(idx == 5 && !rd_n) && n < 400) begin @(negedge clk); n++; end
        check("rst reached ch5 read", int'(rd_n), 0);
        reset = 1;
        #1;
        check("mid rst conv_n", int'(conv_n), 1);
        check("mid rst cs_n", int'(cs_n), 1);
        check("mid rst rd_n", int'(rd_n), 1);
        check("mid rst valid", int'(valid), 0);
        check("mid rst sample", int'(sample), 0);
        check("mid rst chan", int'(chan), 0);
        check("mid rst flags", int'({overrun, timeout, frame_done}), 0);
        exp_q.delete();
        @(negedge clk);
        push_frame(16'h5000);
        en = 1; reset = 0;
        n = 0;
        while (conv_n && n < 300) begin @(negedge clk); n++; end
        check("post rst latency", n, P + 1);
        en = 0;
        finish_frame("post rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
